// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} ldr_state_e;
    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;
endpackage

// File: rtl/imem_word_packer.sv
// Collects little-endian bytes into 32-bit words; word_valid fires combinationally
// on the accept of the 4th byte so the caller can register the write port.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_fire,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  cnt;
    logic [23:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sh  <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (in_fire) begin
            cnt <= cnt + 2'd1;
            sh  <= {in_data, sh[23:8]};
        end
    end

    assign word_valid = in_fire && (cnt == 2'(BYTES_PER_WORD - 1));
    assign word       = {in_data, sh};
endmodule

// File: rtl/imem_loader.sv
// Boot-time imem writer: header (16-bit word count) then little-endian words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 sum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [INST_WIDTH-1:0] imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  core_hold
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam ldr_state_e FIN = CSUM;
`else
    localparam ldr_state_e FIN = DONE;
`endif

    ldr_state_e  state, state_n;
    logic        fire, load, last_wr, pk_valid, csum_ok;
    logic [31:0] pk_word;
    logic [7:0]  n_lo;
    logic [15:0] n_words, word_idx, hdr_n;

    assign hdr_n   = {in_data, n_lo};
    assign load    = start && (state == IDLE || state == DONE || state == ERR);
    assign fire    = in_valid && in_ready;
    // word_idx is already incremented during the strobe, so the last write sees idx == N
    assign last_wr = (state == DATA) && imem_we && (word_idx == n_words);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     csum <= '0;
        else if (load)                  csum <= '0;
        else if (state == DATA && fire) csum <= csum + in_data;
    end
    assign csum_ok = (csum == in_data);
`else
    assign csum_ok = 1'b0;
`endif

    imem_word_packer u_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (load),
        .in_fire    (state == DATA && fire),
        .in_data    (in_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_n = HDR0;
            HDR0:            if (fire) state_n = HDR1;
            HDR1: if (fire) begin
                if (hdr_n == 16'd0)              state_n = FIN;
                else if (hdr_n > 16'(DEPTH))     state_n = ERR;
                else                             state_n = DATA;
            end
            DATA:            if (last_wr) state_n = FIN;
            CSUM:            if (fire) state_n = csum_ok ? DONE : ERR;
            default:         state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        core_hold = 1'b1;
        case (state)
            HDR0, HDR1, CSUM: begin in_ready = 1'b1; busy = 1'b1; end
            // no trailing data byte may slip in during the final write strobe
            DATA:             begin in_ready = !last_wr; busy = 1'b1; end
            DONE:             begin done = 1'b1; core_hold = 1'b0; end
            ERR:              error = 1'b1;
            default:          ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lo       <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= pk_valid;
            if (load) begin
                word_idx <= '0;
                n_words  <= '0;
            end else begin
                if (state == HDR0 && fire) n_lo    <= in_data;
                if (state == HDR1 && fire) n_words <= hdr_n;
                if (pk_valid) begin
                    imem_waddr <= ADDR_WIDTH'({word_idx, 2'b00});
                    imem_wdata <= INST_WIDTH'(pk_word);
                    word_idx   <= word_idx + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream model predicts every imem write.
module tb_imem_loader;
    localparam int DEPTH = 256;

    logic        clk, rst_n, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, imem_we, busy, done, error, core_hold;
    logic [31:0] imem_waddr, imem_wdata;

    int ncmp = 0;
    int nerr = 0;
    logic [7:0]  stream[$];
    logic [63:0] exp_q[$];

    imem_loader #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .error(error), .core_hold(core_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Every write strobe must match the next predicted (addr, data) pair.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {imem_waddr, imem_wdata}, 64'hx);
                end else begin
                    chk("write", {imem_waddr, imem_wdata}, exp_q.pop_front());
                end
            end
            chk("hold_vs_done", core_hold, !done);
        end
    end

    // Predicts the writes produced by the first nsend bytes of stream.
    task automatic model(input int nsend);
        int n, nw, k;
        n = int'(stream[0]) + 256 * int'(stream[1]);
        if (n > DEPTH) return;
        nw = (nsend - 2) / 4;
        if (nw > n) nw = n;
        for (int i = 0; i < nw; i++) begin
            k = 2 + 4 * i;
            exp_q.push_back({32'(4 * i), stream[k+3], stream[k+2], stream[k+1], stream[k]});
        end
    endtask

    task automatic put_byte(input logic [7:0] b, input logic st);
        bit ok;
        ok = 0;
        in_data = b; in_valid = 1'b1; start = st;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; start = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send(input int nsend, input int gap, input int st_a, input int st_b);
        for (int i = 0; i < nsend; i++) begin
            put_byte(stream[i], (i == st_a) || (i == st_b));
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", in_ready, 1);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", error, 0);
    endtask

    task automatic check_end(input string nm, input logic d, input logic e);
        repeat (3) begin @(posedge clk); #1; end
        chk({nm, "_done"}, done, d);
        chk({nm, "_error"}, error, e);
        chk({nm, "_hold"}, core_hold, !d);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_ready"}, in_ready, 0);
        chk({nm, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic load_img1();
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_hold", core_hold, 1);
        chk("rst_addr", imem_waddr, 0);
        chk("rst_data", imem_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: two-word image
        load_img1();
        model(10);
        chk("model_w0", exp_q[0], {32'h0, 32'h00000013});
        chk("model_w1", exp_q[1], {32'h4, 32'h00100093});
        do_start();
        send(10, 0, -1, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        put_byte(8'hB6, 1'b0);
`endif
        check_end("t1", 1, 0);

        // 2: empty image
        stream = '{8'h00, 8'h00};
        do_start();
        send(2, 0, -1, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        put_byte(8'h00, 1'b0);
`endif
        @(posedge clk); #1;
        chk("t2_done_timing", done, 1);
        check_end("t2", 1, 0);

        // 3: N = 257 exceeds depth
        stream = '{8'h01, 8'h01};
        do_start();
        send(2, 0, -1, -1);
        check_end("t3", 0, 1);

        // 4: gaps and ignored start pulses, including on the last data byte
        load_img1();
        model(10);
        do_start();
        send(10, 1, 3, 9);
`ifdef IMEM_LOADER_CHECKSUM_EN
        put_byte(8'hB6, 1'b0);
`endif
        check_end("t4", 1, 0);

        // 5: reset mid-load, then a clean reload
        load_img1();
        model(8);
        do_start();
        send(8, 0, -1, -1);
        chk("t5_w0_seen", exp_q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("t5_ready", in_ready, 0);
        chk("t5_we", imem_we, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_error", error, 0);
        chk("t5_hold", core_hold, 1);
        chk("t5_addr", imem_waddr, 0);
        chk("t5_data", imem_wdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        model(10);
        do_start();
        send(10, 0, -1, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        put_byte(8'hB6, 1'b0);
`endif
        check_end("t5_reload", 1, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: checksum match / mismatch
        load_img1();
        model(10);
        do_start();
        send(10, 0, -1, -1);
        put_byte(8'hB6, 1'b0);
        check_end("t6_ok", 1, 0);
        load_img1();
        model(10);
        do_start();
        send(10, 0, -1, -1);
        put_byte(8'hB7, 1'b0);
        check_end("t6_bad", 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
